// File: rtl/booth_multiplier_seq.sv
// -----------------------------------------------------------------------------
// booth_multiplier_seq
//
// Sequential radix-2 Booth multiplier. One operand pair is accepted per start
// pulse while idle. One Booth iteration is retired per clock. The full-width
// product is returned together with a single-cycle done strobe.
//
// Parameters
//   WIDTH        operand width in bits (2..32)
//   SIGNED_MODE  1 = two's complement operands, 0 = unsigned operands
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   start         request, sampled only while idle
//   multiplicand  operand M, captured on the accepting edge
//   multiplier    operand Q, captured on the accepting edge
//   busy          high from the edge after an accepted start until done completes
//   done          single-cycle strobe, product is valid
//   product       result register, held until the next completion
// -----------------------------------------------------------------------------
module booth_multiplier_seq #(
  parameter int WIDTH       = 8,
  parameter bit SIGNED_MODE = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  // Unsigned operands need one extra iteration and one extra multiplier bit
  // so that the zero-extended value is seen as non-negative by the recoder.
  localparam int ITER_N = SIGNED_MODE ? WIDTH : WIDTH + 1;
  localparam int AW     = WIDTH + 1;
  localparam int QW     = SIGNED_MODE ? WIDTH : WIDTH + 1;
  localparam int CW     = $clog2(ITER_N + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(ITER_N);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               state_r,   state_nxt_s;
  logic [AW-1:0]        acc_r,     acc_nxt_s;
  logic [AW-1:0]        mcand_r,   mcand_nxt_s;
  logic [QW-1:0]        mplier_r,  mplier_nxt_s;
  logic                 q_m1_r,    q_m1_nxt_s;
  logic [CW-1:0]        count_r,   count_nxt_s;
  logic                 busy_r,    busy_nxt_s;
  logic                 done_r,    done_nxt_s;
  logic [2*WIDTH-1:0]   product_r, product_nxt_s;
  logic [AW-1:0]        sum_s;

  // The extra accumulator bit keeps -2^(WIDTH-1) representable after negation.
  function automatic logic [AW-1:0] ext_mcand(input logic [WIDTH-1:0] v);
    logic [AW-1:0] r;
    if (SIGNED_MODE) begin
      r = {v[WIDTH-1], v};
    end else begin
      r = {1'b0, v};
    end
    return r;
  endfunction

  // Multiplier is used as-is in signed mode and zero-extended in unsigned mode.
  function automatic logic [QW-1:0] ext_mplier(input logic [WIDTH-1:0] v);
    return QW'(v);
  endfunction

  // Booth recoding of the current bit pair selects subtract, add or hold.
  always_comb begin
    sum_s = acc_r;
    case ({mplier_r[0], q_m1_r})
      2'b10:   sum_s = acc_r - mcand_r;
      2'b01:   sum_s = acc_r + mcand_r;
      default: sum_s = acc_r;
    endcase
  end

  // Next-state and datapath update for the IDLE / RUN / DONE sequence.
  always_comb begin
    state_nxt_s   = state_r;
    acc_nxt_s     = acc_r;
    mcand_nxt_s   = mcand_r;
    mplier_nxt_s  = mplier_r;
    q_m1_nxt_s    = q_m1_r;
    count_nxt_s   = count_r;
    busy_nxt_s    = busy_r;
    done_nxt_s    = 1'b0;
    product_nxt_s = product_r;

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          acc_nxt_s    = {AW{1'b0}};
          mcand_nxt_s  = ext_mcand(multiplicand);
          mplier_nxt_s = ext_mplier(multiplier);
          q_m1_nxt_s   = 1'b0;
          count_nxt_s  = {CW{1'b0}};
          busy_nxt_s   = 1'b1;
          state_nxt_s  = ST_RUN;
        end else begin
          busy_nxt_s   = 1'b0;
          state_nxt_s  = ST_IDLE;
        end
      end

      ST_RUN: begin
        // Arithmetic shift of {A, Qx, Q_-1} right by one, sign-filled from A.
        acc_nxt_s    = {sum_s[AW-1], sum_s[AW-1:1]};
        mplier_nxt_s = {sum_s[0], mplier_r[QW-1:1]};
        q_m1_nxt_s   = mplier_r[0];
        count_nxt_s  = count_r + CW'(1);
        busy_nxt_s   = 1'b1;
        if (count_nxt_s == LAST_CNT) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end

      ST_DONE: begin
        // Only the low 2*WIDTH bits carry information; the rest is sign fill.
        product_nxt_s = (2*WIDTH)'({acc_r, mplier_r});
        done_nxt_s    = 1'b1;
        busy_nxt_s    = 1'b0;
        state_nxt_s   = ST_IDLE;
      end

      default: begin
        busy_nxt_s  = 1'b0;
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, datapath and output registers; reset aborts any multiply in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      acc_r     <= {AW{1'b0}};
      mcand_r   <= {AW{1'b0}};
      mplier_r  <= {QW{1'b0}};
      q_m1_r    <= 1'b0;
      count_r   <= {CW{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      product_r <= {(2*WIDTH){1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      acc_r     <= acc_nxt_s;
      mcand_r   <= mcand_nxt_s;
      mplier_r  <= mplier_nxt_s;
      q_m1_r    <= q_m1_nxt_s;
      count_r   <= count_nxt_s;
      busy_r    <= busy_nxt_s;
      done_r    <= done_nxt_s;
      product_r <= product_nxt_s;
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign product = product_r;

endmodule
